// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge.
package wb_sram_bridge_pkg;

    // Default geometry: two banks of 512 x 32-bit words.
    localparam int ROW_W     = 9;
    localparam int NUM_BANKS = 2;
    localparam int BANK_BIT  = ROW_W;

    // Lowest byte-address bit that takes part in the window compare.
    // The window spans NUM_BANKS * 2^ROW_W words = 4 KiB.
    localparam int WIN_LSB   = BANK_BIT + 3;

    // Wishbone side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } wb_state_e;

    // True when adr falls in the same aligned window as base.
    function automatic logic win_hit(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int          lsb);
        return (adr >> lsb) == (base >> lsb);
    endfunction

endpackage

// File: rtl/sram_read_mux.sv
// NUM_BANKS-way selector for SRAM read data; one copy per consumer.
module sram_read_mux
    import wb_sram_bridge_pkg::*;
#(
    parameter int NUM_BANKS = wb_sram_bridge_pkg::NUM_BANKS,
    parameter int DW        = 32,
    localparam int SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic [NUM_BANKS-1:0][DW-1:0] dout,
    input  logic [SEL_W-1:0]             sel,
    output logic [DW-1:0]                q
);

    // Pure combinational bank select.
    assign q = dout[sel];

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone classic responder onto two shared SRAM banks. The core's native
// port always wins the command bus; Wishbone requests stall in REQ until
// the core goes quiet.
module wb_sram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ROW_W     = wb_sram_bridge_pkg::ROW_W,
    parameter int          NUM_BANKS = wb_sram_bridge_pkg::NUM_BANKS,
    localparam int         BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int         AW        = ROW_W + BANK_W
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    // Wishbone slave
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    // Core native port
    input  logic [AW-1:0]        core_addr,
    input  logic                 core_ce,
    input  logic                 core_we,
    input  logic [3:0]           core_wm,
    input  logic [31:0]          core_wdata,
    output logic [31:0]          core_rdata,
    // Shared SRAM command bus (port 0 of each bank)
    output logic [NUM_BANKS-1:0] sram_csb,
    output logic                 sram_web,
    output logic [3:0]           sram_wmask,
    output logic [ROW_W-1:0]     sram_addr,
    output logic [31:0]          sram_din,
    input  logic [31:0]          sram_dout0,
    input  logic [31:0]          sram_dout1
);

    import wb_sram_bridge_pkg::*;

    // Byte address bits: [1:0] byte lane, [ROW_W+1:2] row, then bank.
    localparam int WIN_LSB_L = AW + 2;

    wb_state_e             state;
    logic [ROW_W-1:0]      req_row;
    logic [BANK_W-1:0]     req_bank;
    logic                  req_we;
    logic [3:0]            req_sel;
    logic [31:0]           req_dat;
    logic [BANK_W-1:0]     core_bank_q;

    logic [NUM_BANKS-1:0][31:0] dout_all;
    logic [31:0]           core_mux_q;
    logic [31:0]           wb_mux_q;

    logic                  core_act;
    logic                  wb_issue;
    logic                  wb_hit;
    logic                  unused_adr_lsb;

    assign dout_all       = {sram_dout1, sram_dout0};
    assign core_act       = ~core_ce;
    // Wishbone owns the bus only when the core is idle and the master is
    // still in its cycle; a dropped cyc in REQ must never reach the SRAM.
    assign wb_issue       = (state == ST_REQ) && wbs_cyc_i && core_ce;
    assign wb_hit         = wbs_cyc_i && wbs_stb_i &&
                            win_hit(wbs_adr_i, BASE_ADDR, WIN_LSB_L);
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    // Read data for the core follows the bank it addressed last cycle.
    sram_read_mux #(.NUM_BANKS(NUM_BANKS), .DW(32)) u_core_mux (
        .dout (dout_all),
        .sel  (core_bank_q),
        .q    (core_mux_q)
    );

    // Read data for Wishbone follows the registered request bank.
    sram_read_mux #(.NUM_BANKS(NUM_BANKS), .DW(32)) u_wb_mux (
        .dout (dout_all),
        .sel  (req_bank),
        .q    (wb_mux_q)
    );

    assign core_rdata = core_mux_q;

    // Command bus arbitration: core first, then a pending Wishbone access.
    always_comb begin
        sram_csb   = '1;
        sram_web   = 1'b0;
        sram_wmask = 4'b0000;
        sram_addr  = '0;
        sram_din   = '0;
        if (core_act) begin
            sram_csb[core_addr[AW-1 -: BANK_W]] = 1'b0;
            sram_web   = core_we;
            sram_wmask = core_wm;
            sram_addr  = core_addr[ROW_W-1:0];
            sram_din   = core_wdata;
        end else if (wb_issue) begin
            sram_csb[req_bank] = 1'b0;
            sram_web   = ~req_we;
            sram_wmask = req_we ? req_sel : 4'b0000;
            sram_addr  = req_row;
            sram_din   = req_dat;
        end
    end

    // Remember which bank the core read so the next cycle's data is steered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            core_bank_q <= '0;
        else if (core_act)
            core_bank_q <= core_addr[AW-1 -: BANK_W];
    end

    // Wishbone sequencer: latch request, wait for the bus, capture, ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            req_row   <= '0;
            req_bank  <= '0;
            req_we    <= 1'b0;
            req_sel   <= 4'b0000;
            req_dat   <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wb_hit) begin
                        req_row  <= wbs_adr_i[ROW_W+1:2];
                        req_bank <= wbs_adr_i[ROW_W+2 +: BANK_W];
                        req_we   <= wbs_we_i;
                        req_sel  <= wbs_sel_i;
                        req_dat  <= wbs_dat_i;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i)
                        state <= ST_IDLE;
                    else if (core_ce)
                        state <= req_we ? ST_ACK : ST_WAIT;
                end
                ST_WAIT: begin
                    wbs_dat_o <= wb_mux_q;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    // A master that already left the cycle gets no ack.
                    wbs_ack_o <= wbs_cyc_i;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge: behavioural SRAM banks plus a
// word-level shadow memory as the reference.
module tb_wb_sram_bridge;

    logic        clk;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [9:0]  core_addr;
    logic        core_ce, core_we;
    logic [3:0]  core_wm;
    logic [31:0] core_wdata, core_rdata;
    logic [1:0]  sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout0, sram_dout1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [2][512];

    wb_sram_bridge #(.BASE_ADDR(32'h3000_0000), .ROW_W(9), .NUM_BANKS(2)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_addr  (core_addr),
        .core_ce    (core_ce),
        .core_we    (core_we),
        .core_wm    (core_wm),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout0 (sram_dout0),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int b, input int r);
        return 32'h5A00_0000 | (b << 20) | (r * 7 + 1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  m);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++)
            if (m[k]) res[8*k +: 8] = new_w[8*k +: 8];
        return res;
    endfunction

    function automatic logic [31:0] wb_adr(input logic bk, input logic [8:0] rw);
        return {20'h30000, bk, rw, 2'($urandom_range(0, 3))};
    endfunction

    // Behavioural 1rw SRAM banks: data appears the cycle after csb is sampled.
    logic [31:0] bmem [2][512];
    logic [31:0] dout_r [2];
    assign sram_dout0 = dout_r[0];
    assign sram_dout1 = dout_r[1];
    initial begin
        for (int b = 0; b < 2; b++) begin
            dout_r[b] <= '0;
            for (int r = 0; r < 512; r++) bmem[b][r] <= pat(b, r);
        end
        forever begin
            @(posedge clk);
            for (int b = 0; b < 2; b++) begin
                if (!sram_csb[b]) begin
                    if (!sram_web) begin
                        for (int k = 0; k < 4; k++)
                            if (sram_wmask[k])
                                bmem[b][sram_addr][8*k +: 8] <= sram_din[8*k +: 8];
                    end else begin
                        dout_r[b] <= bmem[b][sram_addr];
                    end
                end
            end
        end
    end

    // Drive one Wishbone cycle and report ack latency from the sampling edge.
    task automatic wb_cycle(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            output int lat, output logic [31:0] rd);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        @(posedge clk);
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", wbs_ack_o); end
        n_tests++;
        if (wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got=%h exp=0", wbs_dat_o); end
        n_tests++;
        if (sram_csb !== 2'b11) begin n_fail++; $display("FAIL reset_csb got=%b exp=11", sram_csb); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (sram_csb !== 2'b11 || wbs_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset csb=%b ack=%b exp csb=11 ack=0", sram_csb, wbs_ack_o);
        end
    endtask

    task automatic test_write;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0804; wbs_dat_i = 32'hCAFE_F00D; wbs_sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sram_csb !== 2'b01 || sram_web !== 1'b0 || sram_addr !== 9'd1 ||
            sram_din !== 32'hCAFE_F00D || sram_wmask !== 4'hF) begin
            n_fail++;
            $display("FAIL wr_bus csb=%b web=%b addr=%0d din=%h wm=%h exp 01/0/1/cafef00d/f",
                     sram_csb, sram_web, sram_addr, sram_din, sram_wmask);
        end
        n_tests++;
        if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_early1 got=%b exp=0", wbs_ack_o); end
        @(negedge clk);
        n_tests++;
        if (wbs_ack_o !== 1'b0 || sram_csb !== 2'b11) begin
            n_fail++; $display("FAIL wr_ack_early2 ack=%b csb=%b exp ack=0 csb=11", wbs_ack_o, sram_csb);
        end
        @(negedge clk);
        n_tests++;
        if (wbs_ack_o !== 1'b1) begin n_fail++; $display("FAIL wr_ack_at2 got=%b exp=1", wbs_ack_o); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width got=%b exp=0", wbs_ack_o); end
        ref_mem[1][1] = 32'hCAFE_F00D;
    endtask

    task automatic test_read;
        int lat;
        logic [31:0] rd;
        wb_cycle(1'b0, 32'h3000_0804, 32'h0, 4'hF, lat, rd);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        n_tests++;
        if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_data got=%h exp=cafef00d", rd); end
        wb_cycle(1'b0, 32'h3000_0010, 32'h0, 4'h3, lat, rd);
        n_tests++;
        if (lat !== 3 || rd !== ref_mem[0][4]) begin
            n_fail++; $display("FAIL rd_bank0 lat=%0d data=%h exp lat=3 data=%h", lat, rd, ref_mem[0][4]);
        end
    endtask

    task automatic test_miss;
        logic bad;
        logic [31:0] miss_adr [3];
        miss_adr[0] = 32'h4000_0000;
        miss_adr[1] = 32'h3000_1000;
        miss_adr[2] = 32'h2FFF_FFFC;
        for (int m = 0; m < 3; m++) begin
            bad = 1'b0;
            @(negedge clk);
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = m[0];
            wbs_adr_i = miss_adr[m]; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
            repeat (10) begin
                @(negedge clk);
                if (sram_csb !== 2'b11 || wbs_ack_o !== 1'b0) bad = 1'b1;
            end
            n_tests++;
            if (bad) begin n_fail++; $display("FAIL miss_%0d adr=%h saw csb/ack activity, exp none", m, miss_adr[m]); end
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        end
    endtask

    task automatic test_core_read;
        ref_mem[0][3] = 32'h1234_5678;
        ref_mem[1][3] = 32'h9ABC_DEF0;
        // Preload through the core write path, then read each bank back.
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            core_ce = 1'b0; core_we = 1'b0; core_addr = {b[0], 9'd3};
            core_wm = 4'hF; core_wdata = ref_mem[b][3];
        end
        @(negedge clk);
        core_ce = 1'b1; core_we = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            core_ce = 1'b0; core_we = 1'b1; core_addr = {b[0], 9'd3};
            #1;
            n_tests++;
            if (sram_csb !== (b == 0 ? 2'b10 : 2'b01) || sram_addr !== 9'd3 || sram_web !== 1'b1) begin
                n_fail++; $display("FAIL core_rd_bus%0d csb=%b addr=%0d web=%b", b, sram_csb, sram_addr, sram_web);
            end
            @(negedge clk);
            core_ce = 1'b1;
            n_tests++;
            if (core_rdata !== ref_mem[b][3]) begin
                n_fail++; $display("FAIL core_rd_data%0d got=%h exp=%h", b, core_rdata, ref_mem[b][3]);
            end
        end
    endtask

    task automatic test_random;
        int lat, bad_lat, bad_dat, bad_core;
        logic [31:0] rd, wd;
        logic bk;
        logic [8:0] rw;
        logic [3:0] m;
        logic we;
        bad_lat = 0; bad_dat = 0; bad_core = 0;
        for (int n = 0; n < 60; n++) begin
            bk = 1'($urandom_range(0, 1));
            rw = 9'($urandom_range(0, 511));
            if (n % 6 == 5) rw = (n % 12 == 5) ? 9'd511 : 9'd0;
            m  = 4'($urandom_range(0, 15));
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                core_ce = 1'b0; core_we = ~we; core_addr = {bk, rw};
                core_wm = m; core_wdata = wd;
                @(negedge clk);
                core_ce = 1'b1; core_we = 1'b1;
                if (we) ref_mem[bk][rw] = merge(ref_mem[bk][rw], wd, m);
                else if (core_rdata !== ref_mem[bk][rw]) begin
                    bad_core++;
                    $display("FAIL rand_core_rd b=%0d r=%0d got=%h exp=%h", bk, rw, core_rdata, ref_mem[bk][rw]);
                end
            end else begin
                wb_cycle(we, wb_adr(bk, rw), wd, m, lat, rd);
                if (lat != (we ? 2 : 3)) begin
                    bad_lat++;
                    $display("FAIL rand_wb_lat we=%b got=%0d exp=%0d", we, lat, we ? 2 : 3);
                end
                if (we) ref_mem[bk][rw] = merge(ref_mem[bk][rw], wd, m);
                else if (rd !== ref_mem[bk][rw]) begin
                    bad_dat++;
                    $display("FAIL rand_wb_rd b=%0d r=%0d got=%h exp=%h", bk, rw, rd, ref_mem[bk][rw]);
                end
            end
        end
        n_tests++; if (bad_lat  != 0) n_fail++;
        n_tests++; if (bad_dat  != 0) n_fail++;
        n_tests++; if (bad_core != 0) n_fail++;
    endtask

    task automatic test_contention;
        int lat;
        logic [8:0] ca [5];
        logic [31:0] exp_d;
        logic bad_bus, bad_core;
        bad_bus = 1'b0; bad_core = 1'b0;
        exp_d = ref_mem[1][77];
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = {20'h30000, 1'b1, 9'd77, 2'b00}; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            ca[k] = 9'($urandom_range(0, 511));
            core_ce = 1'b0; core_we = 1'b1; core_addr = {k[0], ca[k]};
            #1;
            if (sram_csb !== (k[0] ? 2'b01 : 2'b10) || sram_addr !== ca[k] || sram_web !== 1'b1) begin
                bad_bus = 1'b1;
                $display("FAIL cont_bus k=%0d csb=%b addr=%0d exp addr=%0d", k, sram_csb, sram_addr, ca[k]);
            end
            @(posedge clk); #1;
            if (core_rdata !== ref_mem[k[0]][ca[k]] || wbs_ack_o !== 1'b0) begin
                bad_core = 1'b1;
                $display("FAIL cont_core k=%0d got=%h exp=%h ack=%b", k, core_rdata, ref_mem[k[0]][ca[k]], wbs_ack_o);
            end
        end
        core_ce = 1'b1;
        #1;
        n_tests++;
        if (sram_csb !== 2'b01 || sram_addr !== 9'd77 || sram_web !== 1'b1) begin
            n_fail++; $display("FAIL cont_wb_issue csb=%b addr=%0d web=%b exp 01/77/1", sram_csb, sram_addr, sram_web);
        end
        n_tests++; if (bad_bus)  n_fail++;
        n_tests++; if (bad_core) n_fail++;
        lat = -1;
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin lat = i; break; end
        end
        n_tests++;
        if (lat !== 8 || wbs_dat_o !== exp_d) begin
            n_fail++; $display("FAIL cont_ack lat=%0d data=%h exp lat=8 data=%h", lat, wbs_dat_o, exp_d);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic test_abort;
        int lat;
        logic [31:0] rd;
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0100; wbs_dat_i = 32'hBAD0_BAD0; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        core_ce = 1'b0; core_we = 1'b1; core_addr = 10'h2AA;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        core_ce = 1'b1;
        repeat (8) begin
            #1;
            if (sram_csb !== 2'b11 || wbs_ack_o !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL abort_quiet saw csb/ack activity after abort, exp none"); end
        wb_cycle(1'b0, 32'h3000_0100, 32'h0, 4'hF, lat, rd);
        n_tests++;
        if (rd !== ref_mem[0][64]) begin
            n_fail++; $display("FAIL abort_no_write got=%h exp=%h", rd, ref_mem[0][64]);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        logic [31:0] wd;
        wd = $urandom;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0A08; wbs_dat_i = wd; wbs_sel_i = 4'hF;
        @(posedge clk);
        lat1 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin lat1 = i; break; end
        end
        ref_mem[1][130] = wd;
        wbs_we_i = 1'b0;
        lat2 = -1;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin lat2 = i; break; end
        end
        n_tests++;
        if (lat1 !== 2 || lat2 !== 3) begin
            n_fail++; $display("FAIL b2b_latency got=%0d,%0d exp=2,3", lat1, lat2);
        end
        n_tests++;
        if (wbs_dat_o !== ref_mem[1][130]) begin
            n_fail++; $display("FAIL b2b_data got=%h exp=%h", wbs_dat_o, ref_mem[1][130]);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0004; wbs_sel_i = 4'hF;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || sram_csb !== 2'b11) begin
            n_fail++; $display("FAIL mid_reset ack=%b dat=%h csb=%b exp 0/0/11", wbs_ack_o, wbs_dat_o, sram_csb);
        end
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wbs_ack_o !== 1'b0 || sram_csb !== 2'b11) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL mid_reset_quiet ack or csb active after reset, exp none"); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        core_addr = '0; core_ce = 1'b1; core_we = 1'b1; core_wm = 4'h0; core_wdata = '0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 512; r++) ref_mem[b][r] = pat(b, r);
        test_reset;
        test_write;
        test_read;
        test_miss;
        test_core_read;
        test_random;
        test_contention;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
Wishbone classic responder that lets the management SoC read and write the two 512x32 data SRAM banks. It arbitrates against the core's native SRAM port, which always has priority. It sits between the core's mem_* port, the Wishbone slave bus and the two sky130 1rw1r banks (port 0 only). It drives one shared SRAM command bus with per-bank chip selects and steers read data back to whichever side issued the read.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone window base; adr[31:12] must match BASE_ADDR[31:12].
ROW_W, 9, SRAM row address width (512 rows per bank).
NUM_BANKS, 2, bank count; bank index is word-address bit ROW_W.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
core_addr  in  10  core word address; [9] selects bank, [8:0] is the row
core_ce  in  1  core chip enable, active-low
core_we  in  1  core write enable, active-low
core_wm  in  4  core write mask
core_wdata  in  32  core write data
core_rdata  out  32  core read data
sram_csb  out  2  per-bank chip select, active-low
sram_web  out  1  write enable, active-low
sram_wmask  out  4  write mask
sram_addr  out  9  row address
sram_din  out  32  write data
sram_dout0  in  32  bank 0 read data
sram_dout1  in  32  bank 1 read data

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - wbs_ack_o=0, wbs_dat_o=0.
  - sram_csb=2'b11.
  - Core bank register = 0.
- SRAM timing: read data appears on sram_doutN in the cycle after the edge that sampled csb low.
- Command mux (combinational), priority order:
  1. core_ce=0: the core drives the bus.
     - sram_csb[core_addr[9]]=0, the other bank's csb=1.
     - sram_web=core_we, sram_wmask=core_wm.
     - sram_addr=core_addr[8:0], sram_din=core_wdata.
  2. Otherwise, FSM in REQ: the bus is driven from the registered Wishbone request.
  3. Otherwise: sram_csb=2'b11; the other SRAM outputs are don't-care but held at 0.
- Core read path:
  - Bank register loads core_addr[9] on every edge where core_ce=0.
  - core_rdata = bank register ? sram_dout1 : sram_dout0 (combinational).
  - Latency is 1 cycle, identical to a bare SRAM.
- Wishbone FSM, states IDLE, REQ, WAIT, ACK:
  - IDLE: on cyc&stb&window hit, register row=adr[10:2], bank=adr[11], we, sel, dat_i, then go to REQ. Requests that miss the window are ignored and never acked.
  - REQ: if cyc=0, abort to IDLE with no SRAM access. Else, if core_ce=1, issue the access:
    - web=!we.
    - wmask = sel on a write, 4'b0000 on a read.
    - Next state: WAIT for a read, ACK for a write.
  - REQ while core_ce=0: stay in REQ (stall; no timeout).
  - WAIT: capture sram_dout[bank] into wbs_dat_o, then go to ACK.
  - ACK: wbs_ack_o = cyc (exactly one cycle), then go to IDLE. If cyc was dropped, the access completes silently.
- Latency with no contention, counted from the edge sampling stb in IDLE: write ack at +2 cycles, read ack at +3 cycles. Each cycle of core activity while in REQ adds one cycle.
- Back-to-back requests: stb still high in the IDLE cycle after ACK is treated as a new request.
- wbs_dat_o holds its value until the next read capture.
- Reset mid-operation: next state is IDLE, no ack, no pending SRAM access.

Decomposition:
- Shared package:
  - FSM state enum.
  - ROW_W, NUM_BANKS, BANK_BIT.
  - Window-compare helper constant (address upper bits).
- Sub-module: sram_read_mux, the NUM_BANKS-way dout select shared by the core path and the WAIT capture.

Test Plan:
1. Reset held 3 cycles -> wbs_ack_o=0, wbs_dat_o=0, sram_csb=2'b11; released with no traffic -> csb stays 2'b11.
2. WB write adr=0x3000_0804, dat=0xCAFEF00D, sel=0xF, core idle -> +1 cycle: csb=2'b01, web=0, addr=1, din=0xCAFEF00D, wmask=0xF; ack at +2, one cycle wide.
3. WB read adr=0x3000_0804, model returns 0xCAFEF00D on sram_dout1 -> ack at +3 with wbs_dat_o=0xCAFEF00D; adr=0x4000_0000 -> no csb activity, no ack for 10 cycles.
4. Core read core_addr=10'h003 with core_ce=0 for one cycle, sram_dout0=0x1234_5678 -> next cycle core_rdata=0x1234_5678 with csb=2'b10 on the access cycle; repeat with core_addr=10'h203 -> data taken from sram_dout1.
5. Contention: WB read pending, core_ce=0 for 5 consecutive cycles -> SRAM bus follows the core throughout; WB ack arrives at +8 with correct data.
6. Abort and reset: cyc dropped while in REQ under contention -> no WB SRAM access, no ack. Reset asserted in WAIT -> IDLE next cycle, ack never asserted, wbs_dat_o=0.
